fetch_ctrl: RTL and testbench

//  Sequences instruction fetch over a single-outstanding SRAM-like instruction bus. Owns the PC,

---
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch sequencer with delay-slot redirect and flush
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        pending_q, pending_d;
    logic [31:0] target_q, target_d;
    logic        drop_flag_q, drop_flag_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_adel_q, out_adel_d;

    logic        handshake;
    logic        fetch_new;

    // State register; reset abandons any bus transaction in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            pending_q   <= 1'b0;
            target_q    <= 32'h0;
            drop_flag_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            drop_flag_q <= drop_flag_d;
            out_instr_q <= out_instr_d;
            out_adel_q  <= out_adel_d;
        end
    end

    // Next-state: normal sequencing, then flush override, then start of a new fetch at pc_d
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        pending_d   = pending_q;
        target_d    = target_q;
        drop_flag_d = drop_flag_q;
        out_instr_d = out_instr_q;
        out_adel_d  = out_adel_q;
        fetch_new   = 1'b0;
        handshake   = (state_q == S_HOLD) && out_ready;

        // A later redirect simply overwrites an earlier unapplied target
        if (redirect_valid) begin
            pending_d = 1'b1;
            target_d  = redirect_pc;
        end

        case (state_q)
            S_IDLE: fetch_new = 1'b1;
            S_REQ: begin
                if (ireq_addr_ok) begin
                    state_d     = drop_flag_q ? S_DROP : S_WAIT;
                    drop_flag_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (iresp_data_ok) begin
                    out_instr_d = iresp_data;
                    out_adel_d  = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    fetch_new = 1'b1;
                    pending_d = 1'b0;
                    // Redirect arriving with the delay-slot handshake takes effect directly
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (pending_q) begin
                        pc_d = target_q;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_DROP: fetch_new = iresp_data_ok;
            default: state_d = S_IDLE;
        endcase

        if (flush_valid) begin
            pc_d      = flush_pc;
            pending_d = 1'b0;
            case (state_q)
                S_IDLE, S_HOLD: fetch_new = 1'b1;
                S_REQ: begin
                    // The request already on the bus cannot be withdrawn; its response is discarded
                    fetch_new = 1'b0;
                    if (ireq_addr_ok) begin
                        state_d     = S_DROP;
                        drop_flag_d = 1'b0;
                    end else begin
                        state_d     = S_REQ;
                        drop_flag_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok) begin
                        fetch_new = 1'b1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                default: ;
            endcase
        end

        // Misaligned PCs never reach the bus; they are presented directly as address errors
        if (fetch_new) begin
            if (pc_d[1:0] != 2'b00) begin
                state_d     = S_HOLD;
                out_adel_d  = 1'b1;
                out_instr_d = 32'h0;
            end else begin
                state_d    = S_REQ;
                req_addr_d = pc_d;
                out_adel_d = 1'b0;
            end
        end
    end

    assign ireq_valid = (state_q == S_REQ);
    assign ireq_addr  = req_addr_q;
    assign out_valid  = (state_q == S_HOLD);
    assign out_instr  = out_instr_q;
    assign out_pc     = pc_q;
    assign out_adel   = out_adel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_adel;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_addr_ok   (ireq_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_valid    (flush_valid),
        .flush_pc       (flush_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_adel       (out_adel)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   delivered = 0;
    bit   run = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.adel  = (pc[1:0] != 2'b00);
        e.instr = e.adel ? 32'h0 : mem_word(pc);
        return e;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int r;
        r = $urandom_range(0, 9);
        t = $urandom & 32'h0000_3FFC;
        if (r == 0) t[1:0] = 2'($urandom_range(1, 3));
        if (r == 1) t = 32'hFFFF_FFF4;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus responder: random accept delay, 1-3 cycle response latency, one outstanding
    initial begin
        bit          outst;
        bit          held;
        int          cnt;
        logic [31:0] acc_addr;
        logic [31:0] held_addr;
        outst = 0; held = 0; cnt = 0; acc_addr = 0; held_addr = 0;
        wait (run);
        forever begin
            @(posedge clk); #1;
            ireq_addr_ok  = 1'b0;
            iresp_data_ok = 1'b0;
            iresp_data    = $urandom;
            if (outst) begin
                check("single_outstanding", {31'b0, ireq_valid}, 32'h0);
                held = 0;
                cnt--;
                if (cnt == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem_word(acc_addr);
                    outst         = 0;
                end
            end else if (ireq_valid) begin
                if (held) check("ireq_addr_hold", ireq_addr, held_addr);
                check("ireq_addr_align", {30'b0, ireq_addr[1:0]}, 32'h0);
                if ($urandom_range(0, 2) != 0) begin
                    ireq_addr_ok = 1'b1;
                    outst        = 1;
                    cnt          = $urandom_range(1, 3);
                    acc_addr     = ireq_addr;
                    held         = 0;
                end else begin
                    held      = 1;
                    held_addr = ireq_addr;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Monitor: every presented instruction must match the head of the expected queue
    initial begin
        exp_t e;
        wait (run);
        forever begin
            @(negedge clk);
            if (ireq_valid && out_valid) begin
                checks++;
                errors++;
                $display("FAIL req_while_valid: ireq_valid=1 with out_valid=1 at %0t", $time);
            end
            if (out_valid && !flush_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_pc=%h with empty queue", out_pc);
                end else begin
                    e = exp_q[0];
                    check("out_pc", out_pc, e.pc);
                    check("out_adel", {31'b0, out_adel}, {31'b0, e.adel});
                    check("out_instr", out_instr, e.instr);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    // Stimulus and reference model of the delivered PC stream
    initial begin
        bit          fl, rd, hs, pend;
        logic [31:0] tgt, rpc, fpc, nxt;
        int          stall;
        pend = 0; tgt = 0; stall = 0;
        reset          = 1'b1;
        ireq_addr_ok   = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        flush_valid    = 1'b0;
        flush_pc       = 32'h0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ireq_valid", {31'b0, ireq_valid}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_adel", {31'b0, out_adel}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'b0, ireq_valid}, 32'h0);
        @(posedge clk); #1;
        check("first_req_valid", {31'b0, ireq_valid}, 32'h1);
        check("first_req_addr", ireq_addr, 32'h0);
        exp_q.push_back(mk(32'h0));
        run = 1'b1;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge clk); #1;
            fl  = ($urandom_range(0, 29) == 0);
            rd  = !fl && ($urandom_range(0, 9) == 0);
            rpc = rand_target();
            fpc = rand_target();
            out_ready      = !fl && ($urandom_range(0, 3) != 0);
            flush_valid    = fl;
            flush_pc       = fl ? fpc : $urandom;
            redirect_valid = rd;
            redirect_pc    = rd ? rpc : $urandom;
            hs = out_valid && out_ready;
            if (fl) begin
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                exp_q.push_back(mk(fpc));
                pend = 0;
            end else if (hs) begin
                nxt = rd ? rpc : (pend ? tgt : exp_q[$].pc + 32'd4);
                pend = 0;
                exp_q.push_back(mk(nxt));
            end else if (rd) begin
                pend = 1;
                tgt  = rpc;
            end
            stall = hs ? 0 : stall + 1;
            if (stall > 300) begin
                checks++;
                errors++;
                $display("FAIL progress: no handshake for %0d cycles", stall);
                break;
            end
        end
        out_ready      = 1'b0;
        flush_valid    = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) @(posedge clk);
        check("delivered_enough", {31'b0, (delivered >= 200)}, 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
